// File: rtl/i2s2_tx_scheduler.sv
// i2s2_tx_scheduler: round-robin arbiter that feeds the Pmod I2S2 codec TX
// AXIS port from several stereo sources. A grant covers a whole L/R packet,
// and a stall watchdog finishes an abandoned right word with silence.
module i2s2_tx_scheduler #(
    parameter int NR_OF_SOURCES_P = 4,
    parameter int DATA_WIDTH_P    = 32,
    parameter int TIMEOUT_P       = 1024
) (
    input  logic                                      clk_mclk,
    input  logic                                      rst,
    input  logic [NR_OF_SOURCES_P*DATA_WIDTH_P-1:0]   src_axis_s_data,
    input  logic [NR_OF_SOURCES_P-1:0]                src_axis_s_valid,
    output logic [NR_OF_SOURCES_P-1:0]                src_axis_s_ready,
    input  logic [NR_OF_SOURCES_P-1:0]                src_axis_s_last,
    output logic [DATA_WIDTH_P-1:0]                   tx_axis_m_data,
    output logic                                      tx_axis_m_valid,
    input  logic                                      tx_axis_m_ready,
    output logic                                      tx_axis_m_last,
    input  logic                                      cr_enable,
    input  logic                                      cr_mute,
    output logic [NR_OF_SOURCES_P-1:0]                sr_grant,
    output logic [15:0]                               sr_timeout_count,
    output logic [15:0]                               sr_protocol_errors
);

    localparam int IDX_W = $clog2(NR_OF_SOURCES_P);
    localparam int TMR_W = $clog2(TIMEOUT_P + 1);

    typedef enum logic [1:0] {IDLE, SEND_L, SEND_R, FILL_R} state_t;

    state_t            state;
    logic [IDX_W-1:0]  grant_idx;
    logic [IDX_W-1:0]  last_grant;
    logic [TMR_W-1:0]  timer;

    logic              pick_found;
    logic [IDX_W-1:0]  pick_idx;
    int                cand;

    logic [DATA_WIDTH_P-1:0] g_data;
    logic                    g_valid;
    logic                    g_last;
    logic                    timer_expired;

    // Counters stick at full scale instead of wrapping.
    function automatic logic [15:0] sat_inc(input logic [15:0] v);
        return (v == 16'hFFFF) ? v : v + 16'd1;
    endfunction

    assign timer_expired = (timer == TMR_W'(TIMEOUT_P - 1));

    // Round-robin pick: first valid source above the last one served, with wrap.
    always_comb begin
        pick_found = 1'b0;
        pick_idx   = '0;
        cand       = 0;
        for (int k = 1; k <= NR_OF_SOURCES_P; k++) begin
            cand = int'(last_grant) + k;
            if (cand >= NR_OF_SOURCES_P)
                cand = cand - NR_OF_SOURCES_P;
            if (!pick_found && src_axis_s_valid[IDX_W'(cand)]) begin
                pick_found = 1'b1;
                pick_idx   = IDX_W'(cand);
            end
        end
    end

    // Select the granted source's AXIS signals.
    always_comb begin
        g_data  = '0;
        g_valid = 1'b0;
        g_last  = 1'b0;
        for (int i = 0; i < NR_OF_SOURCES_P; i++) begin
            if (grant_idx == IDX_W'(i)) begin
                g_data  = src_axis_s_data[i*DATA_WIDTH_P +: DATA_WIDTH_P];
                g_valid = src_axis_s_valid[i];
                g_last  = src_axis_s_last[i];
            end
        end
    end

    // Forwarding path to the codec; last is set by position in the packet, not by the source.
    always_comb begin
        tx_axis_m_valid  = 1'b0;
        tx_axis_m_data   = '0;
        tx_axis_m_last   = 1'b0;
        src_axis_s_ready = '0;
        case (state)
            SEND_L, SEND_R: begin
                tx_axis_m_valid             = g_valid;
                tx_axis_m_data              = cr_mute ? '0 : g_data;
                tx_axis_m_last              = (state == SEND_R);
                src_axis_s_ready[grant_idx] = tx_axis_m_ready;
            end
            FILL_R: begin
                tx_axis_m_valid = 1'b1;
                tx_axis_m_last  = 1'b1;
            end
            default: ;
        endcase
    end

    // Packet FSM with stall watchdog and status counters.
    always_ff @(posedge clk_mclk) begin
        if (rst) begin
            state              <= IDLE;
            grant_idx          <= '0;
            last_grant         <= IDX_W'(NR_OF_SOURCES_P - 1);
            sr_grant           <= '0;
            timer              <= '0;
            sr_timeout_count   <= '0;
            sr_protocol_errors <= '0;
        end else begin
            case (state)
                IDLE: begin
                    timer <= '0;
                    if (cr_enable && pick_found) begin
                        grant_idx  <= pick_idx;
                        last_grant <= pick_idx;
                        sr_grant   <= NR_OF_SOURCES_P'(1) << pick_idx;
                        state      <= SEND_L;
                    end
                end
                SEND_L: begin
                    if (g_valid) begin
                        timer <= '0;
                        if (tx_axis_m_ready) begin
                            state <= SEND_R;
                            if (g_last)
                                sr_protocol_errors <= sat_inc(sr_protocol_errors);
                        end
                    end else if (timer_expired) begin
                        // Nothing reached the codec yet, so the packet is simply dropped.
                        timer            <= '0;
                        sr_grant         <= '0;
                        state            <= IDLE;
                        sr_timeout_count <= sat_inc(sr_timeout_count);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                SEND_R: begin
                    if (g_valid) begin
                        timer <= '0;
                        if (tx_axis_m_ready) begin
                            sr_grant <= '0;
                            state    <= IDLE;
                        end
                    end else if (timer_expired) begin
                        // Left word already went out: finish the frame with a silent right word.
                        timer            <= '0;
                        state            <= FILL_R;
                        sr_timeout_count <= sat_inc(sr_timeout_count);
                    end else begin
                        timer <= timer + 1'b1;
                    end
                end
                FILL_R: begin
                    timer <= '0;
                    if (tx_axis_m_ready) begin
                        sr_grant <= '0;
                        state    <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/i2s2_tx_scheduler.md
Name: i2s2_tx_scheduler

Overview:
Round-robin scheduler that shares the single stereo TX AXIS input of the Pmod I2S2 codec controller among several audio sources. Each source offers 2-word packets (left word, then right word with last). Grants are held for a whole packet so left/right pairs never interleave. A stall watchdog completes a stalled packet with silence. Mute and enable controls are provided. Sits in the clk_mclk domain (~22.591 MHz), directly in front of the codec TX slave port.

Parameters:
NR_OF_SOURCES_P, 4, number of requesting sources (2..16)
DATA_WIDTH_P, 32, AXIS word width
TIMEOUT_P, 1024, consecutive cycles a granted source may leave valid low before the watchdog acts (≥2)

Ports:
clk_mclk  in  1  clock, codec master-clock domain
rst  in  1  synchronous reset, active-high
src_axis_s_data  in  NR_OF_SOURCES_P*DATA_WIDTH_P  packed source words; source i at [i*DATA_WIDTH_P +: DATA_WIDTH_P]
src_axis_s_valid  in  NR_OF_SOURCES_P  per-source valid
src_axis_s_ready  out  NR_OF_SOURCES_P  per-source ready
src_axis_s_last  in  NR_OF_SOURCES_P  per-source last (set on right word)
tx_axis_m_data  out  DATA_WIDTH_P  to codec TX slave
tx_axis_m_valid  out  1  to codec
tx_axis_m_ready  in  1  from codec
tx_axis_m_last  out  1  to codec
cr_enable  in  1  1 = new grants allowed
cr_mute  in  1  1 = forwarded data forced to zero; handshakes unchanged
sr_grant  out  NR_OF_SOURCES_P  one-hot current grant, 0 when idle
sr_timeout_count  out  16  watchdog events, saturating
sr_protocol_errors  out  16  left words carrying last=1, saturating

Behaviour:
- Reset: state IDLE; all outputs 0; last_grant = NR_OF_SOURCES_P-1, so source 0 is served first; timer 0.
- FSM states: IDLE, SEND_L, SEND_R, FILL_R.
- IDLE:
  - If cr_enable=1 and any src valid, choose the first valid source searching upward from (last_grant+1) mod N, with wrap.
  - Register the choice as grant and last_grant, then go to SEND_L. Arbitration costs 1 cycle.
  - tx valid=0 and all src ready=0 in IDLE.
- SEND_L / SEND_R forwarding (combinational from registered grant g):
  - tx_valid = src_valid[g]
  - tx_data = cr_mute ? 0 : src_data[g]
  - src_ready[g] = tx_ready; other src ready=0
- SEND_L:
  - tx_last forced 0.
  - On handshake go to SEND_R.
  - If src_last[g]=1 on that handshake, still treat the word as left and increment sr_protocol_errors.
- SEND_R:
  - tx_last forced 1 regardless of src_last[g].
  - On handshake go to IDLE and clear grant.
- Watchdog:
  - Timer counts cycles with src_valid[g]=0 in SEND_L/SEND_R. Clear it on src_valid[g]=1 or on any state change.
  - In SEND_L, timer reaching TIMEOUT_P: go to IDLE (nothing was emitted) and increment sr_timeout_count.
  - In SEND_R, timer reaching TIMEOUT_P: go to FILL_R and increment sr_timeout_count.
- FILL_R:
  - tx_valid=1, tx_data=0, tx_last=1, all src ready=0.
  - On tx_ready go to IDLE.
  - This guarantees the codec never receives an orphan left word.
- cr_enable=0 mid-packet: the current packet completes normally; only new grants are blocked.
- cr_mute is sampled every cycle; it may change between the L and R words.
- Counters saturate at 0xFFFF.
- Simultaneous protocol error and timeout cannot occur (different states).
- Reset mid-packet: immediate return to IDLE with outputs 0; a partially sent packet is abandoned.
- Max throughput: one packet per 3 cycles (IDLE+L+R) with continuous valid/ready. This is far above the 44.1 kHz frame rate.

Test Plan:
- Reset, all sources idle, cr_enable=1 -> tx_axis_m_valid=0, sr_grant=0, both counters 0.
- Sources 0..3 each hold one packet (L=0x00i11111, R=0x00i22222), tx_ready=1 -> codec receives packets in order 0,1,2,3. Each packet is 2 beats with last=0/1, and 1 idle cycle separates packets.
- Only sources 1 and 3 continuously valid -> grants alternate 1,3,1,3; never two consecutive grants to the same source.
- Source 2 sends L=0x123456, then holds valid low for TIMEOUT_P cycles -> tx beat data=0, last=1 follows; sr_timeout_count=1; src_axis_s_ready[2] stays 0 during FILL_R.
- cr_mute=1 with source 0 packet 0xABCDEF/0x654321 -> tx data 0,0 with last 0,1. Source handshakes complete and the next packet is granted.
- Source 1 asserts last on its L word -> forwarded with tx last=0, sr_protocol_errors=1, next beat forwarded with last=1. Also: tx_ready held 0 for 500 cycles mid-packet -> no timeout, data held stable.
